// File: rtl/fp_mult_pipe_if.sv
// Operand/result bundle for fp_mult_pipe. Defining FP_MULT_STICKY_STATUS_EN
// adds the sticky status clear input and the accumulated status output.
interface fp_mult_pipe_if;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  rnd;
   logic        out_valid;
   logic [31:0] z;
   logic [7:0]  status;
`ifdef FP_MULT_STICKY_STATUS_EN
   logic        sticky_clr;
   logic [7:0]  status_sticky;

   modport master (
      output in_valid, a, b, rnd, sticky_clr,
      input  out_valid, z, status, status_sticky
   );
   modport slave (
      input  in_valid, a, b, rnd, sticky_clr,
      output out_valid, z, status, status_sticky
   );
`else
   modport master (
      output in_valid, a, b, rnd,
      input  out_valid, z, status
   );
   modport slave (
      input  in_valid, a, b, rnd,
      output out_valid, z, status
   );
`endif
endinterface

// File: rtl/fp_mult_pipe.sv
// Two-stage IEEE-754 single-precision multiplier, denormals flushed, no NaN encoding.
// Optional sticky status accumulator enabled by FP_MULT_STICKY_STATUS_EN.
module fp_mult_pipe #(
   parameter int LATENCY = 2
) (
   input logic          clk,
   input logic          rst,
   fp_mult_pipe_if.slave bus
);

   if (LATENCY != 2) begin : g_bad_latency
      $error("fp_mult_pipe only supports LATENCY = 2");
   end

   typedef enum logic [2:0] {
      RND_NEAR    = 3'b000,
      RND_ZERO    = 3'b001,
      RND_PINF    = 3'b010,
      RND_NINF    = 3'b011,
      RND_NEAR_UP = 3'b100,
      RND_AWAY    = 3'b101
   } rnd_e;

   typedef struct packed {
      logic inexact;
      logic huge;
      logic tiny;
      logic nan;
      logic inf;
      logic zero;
   } flags_t;

   // Stage 1: operand capture
   logic        s1_valid;
   logic [31:0] s1_a;
   logic [31:0] s1_b;
   logic [2:0]  s1_rnd;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_rnd   <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         s1_a     <= bus.a;
         s1_b     <= bus.b;
         s1_rnd   <= bus.rnd;
      end
   end

   // Stage 2 combinational datapath
   logic        sign;
   logic [7:0]  ea, eb;
   logic        a_zero, a_inf, b_zero, b_inf;
   logic [47:0] prod;
   logic        norm;
   logic [23:0] mant;
   logic        guard, sticky, round_up;
   logic [24:0] mant_r;
   logic [9:0]  exp_pre, exp_r;
   logic [22:0] frac;
   logic        overflow, underflow, sat_to_max, sat_to_min;
   flags_t      flags;
   logic [31:0] z_next;
   logic [7:0]  status_next;

   // NOTE: every variable driven here gets a default first, so no path
   // can leave one unassigned and infer a latch.
   always_comb begin
      sign     = s1_a[31] ^ s1_b[31];
      ea       = s1_a[30:23];
      eb       = s1_b[30:23];
      a_zero   = (ea == 8'h00);
      a_inf    = (ea == 8'hFF);
      b_zero   = (eb == 8'h00);
      b_inf    = (eb == 8'hFF);
      prod     = {24'b0, 1'b1, s1_a[22:0]} * {24'b0, 1'b1, s1_b[22:0]};
      norm     = prod[47];
      mant     = norm ? prod[47:24] : prod[46:23];
      guard    = norm ? prod[23] : prod[22];
      sticky   = norm ? (|prod[22:0]) : (|prod[21:0]);
      exp_pre  = {2'b0, ea} + {2'b0, eb} + {9'b0, norm} - 10'd127;

      round_up = 1'b0;
      case (s1_rnd)
         RND_ZERO:    round_up = 1'b0;
         RND_PINF:    round_up = ~sign & (guard | sticky);
         RND_NINF:    round_up = sign & (guard | sticky);
         RND_NEAR_UP: round_up = guard & (sticky | ~sign);
         RND_AWAY:    round_up = guard | sticky;
         default:     round_up = guard & (sticky | mant[0]);
      endcase

      // A rounding carry leaves 1.000...0, so only the exponent moves.
      mant_r    = {1'b0, mant} + {24'b0, round_up};
      exp_r     = exp_pre + {9'b0, mant_r[24]};
      frac      = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      overflow  = ($signed(exp_r) >= 10'sd255);
      underflow = ($signed(exp_r) <= 10'sd0);

      sat_to_max = (s1_rnd == RND_ZERO) || (s1_rnd == RND_PINF && sign) ||
                   (s1_rnd == RND_NINF && !sign);
      sat_to_min = (s1_rnd == RND_AWAY) || (s1_rnd == RND_PINF && !sign) ||
                   (s1_rnd == RND_NINF && sign);

      flags  = '0;
      z_next = {sign, 31'b0};
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin
         z_next    = {sign, 8'hFF, 23'h0};
         flags.nan = 1'b1;
      end else if (a_inf || b_inf) begin
         z_next    = {sign, 8'hFF, 23'h0};
         flags.inf = 1'b1;
      end else if (a_zero || b_zero) begin
         flags.zero = 1'b1;
      end else if (overflow) begin
         flags.huge    = 1'b1;
         flags.inexact = 1'b1;
         if (sat_to_max) begin
            z_next = {sign, 8'hFE, 23'h7FFFFF};
         end else begin
            z_next    = {sign, 8'hFF, 23'h0};
            flags.inf = 1'b1;
         end
      end else if (underflow) begin
         flags.tiny    = 1'b1;
         flags.inexact = 1'b1;
         if (sat_to_min) begin
            z_next = {sign, 8'h01, 23'h0};
         end else begin
            flags.zero = 1'b1;
         end
      end else begin
         z_next        = {sign, exp_r[7:0], frac};
         flags.inexact = guard | sticky;
      end
      status_next = {2'b00, flags};
   end

   // Stage 2: result registers
   logic        out_valid_q;
   logic [31:0] z_q;
   logic [7:0]  status_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         status_q    <= '0;
      end else begin
         out_valid_q <= s1_valid;
         z_q         <= z_next;
         status_q    <= status_next;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.z         = z_q;
   assign bus.status    = status_q;

`ifdef FP_MULT_STICKY_STATUS_EN
   logic [7:0] sticky_q;

   // Clear wins over a same-edge OR-in of a fresh status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sticky_q <= '0;
      end else if (bus.sticky_clr) begin
         sticky_q <= '0;
      end else if (s1_valid) begin
         sticky_q <= sticky_q | status_next;
      end
   end

   assign bus.status_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe with hand-computed vectors,
// back-to-back issue and mid-cycle asynchronous reset.
module tb_fp_mult_pipe;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fp_mult_pipe_if bus ();

   fp_mult_pipe #(.LATENCY(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rnd;
      logic [31:0] z;
      logic [7:0]  st;
   } vec_t;

   localparam int NVEC = 28;
   vec_t vecs [NVEC] = '{
      '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00},
      '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20},
      '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20},
      '{32'h00000000, 32'h7F800000, 3'd0, 32'h7F800000, 8'h04},
      '{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 8'h04},
      '{32'h80000000, 32'h7F800000, 3'd0, 32'hFF800000, 8'h04},
      '{32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 8'h32},
      '{32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h30},
      '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 8'h29},
      '{32'h00800000, 32'h3F000000, 3'd2, 32'h00800000, 8'h28},
      '{32'h80800000, 32'h3F000000, 3'd2, 32'h80000000, 8'h29},
      '{32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 8'h02},
      '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h01},
      '{32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 8'h20},
      '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 8'h20},
      '{32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001, 8'h20},
      '{32'hBF800001, 32'h3FC00000, 3'd4, 32'hBFC00001, 8'h20},
      '{32'h3F800001, 32'h3FC00000, 3'd4, 32'h3FC00002, 8'h20},
      '{32'hBF800001, 32'h3FC00000, 3'd5, 32'hBFC00002, 8'h20},
      '{32'h3F800001, 32'h3FC00000, 3'd6, 32'h3FC00002, 8'h20},
      '{32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 8'h00},
      '{32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 8'h20},
      '{32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 8'h20},
      '{32'hFF000000, 32'h40000000, 3'd3, 32'hFF800000, 8'h32},
      '{32'hFF000000, 32'h40000000, 3'd2, 32'hFF7FFFFF, 8'h30},
      '{32'h80800000, 32'h3F000000, 3'd3, 32'h80800000, 8'h28},
      '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7F800000, 8'h02},
      '{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 8'h01}
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic valid);
      bus.a        = v.a;
      bus.b        = v.b;
      bus.rnd      = v.rnd;
      bus.in_valid = valid;
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      check({tag, "_z"}, bus.z, v.z);
      check({tag, "_status"}, {24'b0, bus.status}, {24'b0, v.st});
   endtask

   // Issue at one negedge, drop valid at the next, sample after edge N+1.
   task automatic run_op(input int idx);
      @(negedge clk);
      drive(vecs[idx], 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_result($sformatf("vec%0d", idx), vecs[idx]);
   endtask

   initial begin
      rst = 1'b0;
      drive('0, 1'b0);
`ifdef FP_MULT_STICKY_STATUS_EN
      bus.sticky_clr = 1'b0;
`endif
      #12;
      check("reset_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset_z", bus.z, 32'd0);
      check("reset_status", {24'b0, bus.status}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) run_op(i);

      @(negedge clk);
      check("idle_valid", {31'b0, bus.out_valid}, 32'd0);

      // Back-to-back issue on three consecutive cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) check_result("b2b0", vecs[0]);
         if (i == 3) check_result("b2b1", vecs[6]);
         if (i == 4) check_result("b2b2", vecs[13]);
         if (i == 0) drive(vecs[0], 1'b1);
         else if (i == 1) drive(vecs[6], 1'b1);
         else if (i == 2) drive(vecs[13], 1'b1);
         else bus.in_valid = 1'b0;
      end

      // Mid-cycle async reset with two ops in flight
      @(negedge clk);
      drive(vecs[0], 1'b1);
      @(negedge clk);
      drive(vecs[6], 1'b1);
      @(negedge clk);
      check_result("pre_rst", vecs[0]);
      drive(vecs[13], 1'b1);
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("async_rst_z", bus.z, 32'd0);
      check("async_rst_status", {24'b0, bus.status}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_valid%0d", i), {31'b0, bus.out_valid}, 32'd0);
      end

`ifdef FP_MULT_STICKY_STATUS_EN
      @(negedge clk);
      bus.sticky_clr = 1'b1;
      @(negedge clk);
      bus.sticky_clr = 1'b0;
      check("sticky_cleared", {24'b0, bus.status_sticky}, 32'd0);
      run_op(6);
      run_op(8);
      check("sticky_accum", {24'b0, bus.status_sticky}, 32'h3B);
      @(negedge clk);
      bus.sticky_clr = 1'b1;
      @(negedge clk);
      bus.sticky_clr = 1'b0;
      check("sticky_clr_again", {24'b0, bus.status_sticky}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
